lzd_fortyeight: RTL and testbench

- 48-bit leading-zero detector/counter with registered outputs.
- Returns the count of leading zeros (MSB = bit 47) and a nonzero flag.
- Feeds the normalizer/exponent path of the log datapath: the mantissa is formed as input << count, and the exponent term is derived from the count.
- Pure datapath block: no handshake; produces a new result every cycle.

---
 rtl/lzd_fortyeight.sv | 47 ++++
 tb/tb_lzd_fortyeight.sv | 113 +++++++++++
 2 files changed

// File: rtl/lzd_fortyeight.sv
// lzd_fortyeight: 48-bit leading-zero counter with registered count/nonzero outputs.
// Define LZD_INREG_EN to add an input register stage (2-cycle latency).
module lzd_fortyeight (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] a,
  output logic [5:0]  p,
  output logic        v
);
  logic [47:0] src;
  logic [11:0] z;
  logic [1:0]  c [12];
  logic [5:0]  p_d, p_q;
  logic        v_d, v_q;
`ifdef LZD_INREG_EN
  logic [47:0] a_d, a_q;
  always_comb a_d = rst ? '0 : a;
  always_ff @(posedge clk) a_q <= a_d;
  assign src = a_q;
`else
  assign src = a;
`endif
  for (genvar i = 0; i < 12; i++) begin : g_nib
    logic [3:0] n;
    assign n    = src[47-4*i -: 4];
    assign z[i] = ~|n;
    assign c[i] = n[3] ? 2'd0 : n[2] ? 2'd1 : n[1] ? 2'd2 : 2'd3;
  end
  // scan from the low nibble up so the most-significant nonzero nibble wins
  always_comb begin
    p_d = '0;
    for (int j = 11; j >= 0; j--)
      if (!z[j]) p_d = {j[3:0], c[j]};
    v_d = ~&z;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      v_q <= 1'b0;
    end else begin
      p_q <= p_d;
      v_q <= v_d;
    end
  end
  assign p = p_q;
  assign v = v_q;
endmodule

// File: tb/tb_lzd_fortyeight.sv
// tb_lzd_fortyeight: directed and randomized checks of lzd_fortyeight against a latency-aligned model.
module tb_lzd_fortyeight;
`ifdef LZD_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] a = '0;
  logic [5:0]  p;
  logic        v;
  int          n_chk = 0;
  int          n_pass = 0;
  int          m_p = 0;
  logic        m_v = 1'b0;
  logic [47:0] m_aq = '0;

  lzd_fortyeight dut (.clk(clk), .rst(rst), .a(a), .p(p), .v(v));

  always #5 clk = ~clk;

  function automatic int ref_lz(input logic [47:0] x);
    int n = 0;
    if (x == 0) return 0;
    while (!x[47]) begin
      x = x << 1;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input logic [47:0] x, input logic r, input bit do_chk);
    a = x;
    rst = r;
    @(posedge clk);
    #1;
    if (LAT == 2) begin
      m_p  = r ? 0 : ref_lz(m_aq);
      m_v  = r ? 1'b0 : (m_aq != 0);
      m_aq = r ? '0 : x;
    end else begin
      m_p = r ? 0 : ref_lz(x);
      m_v = r ? 1'b0 : (x != 0);
    end
    if (do_chk) begin
      chk("model_p", int'(p), m_p);
      chk("model_v", int'(v), int'(m_v));
    end
  endtask

  task automatic directed(input string tag, input logic [47:0] x, input int ep, input int ev);
    for (int i = 0; i < LAT; i++) drive(x, 1'b0, 1'b0);
    chk({tag, "_p"}, int'(p), ep);
    chk({tag, "_v"}, int'(v), ev);
  endtask

  initial begin
    logic [47:0] r48;
    drive(48'hFFFFFFFFFFFF, 1'b1, 1'b0);
    drive(48'hFFFFFFFFFFFF, 1'b1, 1'b0);
    chk("reset_p", int'(p), 0);
    chk("reset_v", int'(v), 0);
    directed("post_reset", 48'hFFFFFFFFFFFF, 0, 1);
    directed("msb",        48'h800000000000, 0, 1);
    directed("lsb",        48'h000000000001, 47, 1);
    directed("zero",       48'h000000000000, 0, 0);
    directed("nib8",       48'h00FFFFFFFFFF, 8, 1);
    directed("nib16",      48'h000080000000, 16, 1);
    directed("mask4",      48'h0F0000000001, 4, 1);
    directed("mid_nib",    48'h000000300000, 26, 1);
    for (int k = 47; k >= 0; k--) begin
      r48 = 48'h1 << k;
      drive(r48, 1'b0, 1'b1);
    end
    for (int k = 47; k >= 0; k--) begin
      r48 = 48'h1 << k;
      directed("walk", r48, 47 - k, 1);
      if (k == 40) break;
    end
    for (int i = 0; i < 10000; i++) begin
      r48 = {$urandom(), $urandom()};
      case (i % 4)
        1: r48 = r48 >> $urandom_range(0, 47);
        2: r48 = r48 & {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
        3: r48 = (i % 32 == 3) ? '0 : (48'h1 << $urandom_range(0, 47)) | (r48 >> 47);
        default: ;
      endcase
      drive(r48, 1'b0, 1'b1);
    end
    drive(48'h000000000100, 1'b0, 1'b1);
    drive(48'h400000000000, 1'b0, 1'b1);
    drive(48'h000000FFFFFF, 1'b1, 1'b0);
    chk("midrst_p", int'(p), 0);
    chk("midrst_v", int'(v), 0);
    drive(48'h000000000010, 1'b0, 1'b1);
    if (LAT == 2) begin
      chk("midrst_hold_p", int'(p), 0);
      chk("midrst_hold_v", int'(v), 0);
      drive(48'h000000000010, 1'b0, 1'b1);
    end
    chk("post_midrst_p", int'(p), 43);
    chk("post_midrst_v", int'(v), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
